trace_dump_engine: RTL and testbench

TRACE_DUMP_ENGINE -- requirements
Module: trace_dump_engine

---
 rtl/trace_dump_engine.sv | 100 ++++++++++
 tb/tb_trace_dump_engine.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_dump_engine.sv
// trace_dump_engine: replays one channel of a circular trace RAM, oldest sample first, through offset/gain correction to a transmitter
module trace_dump_engine #(
   parameter int NUM_CH = 3,
   parameter int DW = 8,
   parameter int AW = 9
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       we,
   input  logic                       cap_en,
   input  logic [AW-1:0]              cap_addr,
   input  logic                       dump_req,
   input  logic [$clog2(NUM_CH)-1:0]  dump_chan,
   input  logic [AW-1:0]              trace_end,
   input  logic [NUM_CH*DW-1:0]       ch_rdata,
   input  logic                       og_valid,
   input  logic [2*DW-1:0]            og_data,
   input  logic                       tx_done,
   output logic                       ram_en,
   output logic [AW-1:0]              ram_addr,
   output logic                       og_req,
   output logic [$clog2(NUM_CH)-1:0]  og_chan,
   output logic [DW-1:0]              tx_data,
   output logic                       trmt,
   output logic                       busy,
   output logic                       dump_done,
   output logic                       dump_abort
);
   typedef enum logic [2:0] {IDLE, GET_OG, RD, CORR, TX} state_t;
   state_t state, state_nx;
   logic [AW-1:0] rd_ptr, count;
   logic [DW-1:0] offset, gain, raw, clamped, corr;
   logic signed [DW+1:0] sum;
   logic [2*DW-1:0] prod;
   logic last, abort, start, og_hit, load, fin;
   assign busy = state != IDLE;
   assign last = count == '1;
   assign abort = busy && we;
   assign start = state == IDLE && dump_req && !we;
   assign og_hit = state == GET_OG && og_valid && !we;
   assign load = state == CORR && !we;
   assign fin = state == TX && tx_done && !we;
   assign og_req = state == GET_OG;
   assign ram_en = we ? cap_en : state == RD;
   assign ram_addr = we ? cap_addr : rd_ptr;
   assign raw = ch_rdata[int'(og_chan)*DW +: DW];
   assign sum = $signed({2'b00, raw}) + $signed({{2{offset[DW-1]}}, offset});
   assign clamped = sum[DW+1] ? '0 : sum[DW] ? '1 : sum[DW-1:0];
   assign prod = {{DW{1'b0}}, clamped} * {{DW{1'b0}}, gain};
   assign corr = prod[2*DW-1] ? '1 : prod[2*DW-2:DW-1];
   // State register
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nx;
   // Next state; capture taking the RAM cancels any dump in progress
   always_comb begin
      state_nx = state;
      if (abort) state_nx = IDLE;
      else
         case (state)
            IDLE:    state_nx = start ? GET_OG : IDLE;
            GET_OG:  state_nx = og_valid ? RD : GET_OG;
            RD:      state_nx = CORR;
            CORR:    state_nx = TX;
            TX:      state_nx = tx_done ? (last ? IDLE : RD) : TX;
            default: state_nx = IDLE;
         endcase
   end
   // Dump bookkeeping, calibration latches and registered outputs
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         og_chan <= '0;
         rd_ptr <= '0;
         count <= '0;
         offset <= '0;
         gain <= '0;
         tx_data <= '0;
         trmt <= 1'b0;
         dump_done <= 1'b0;
         dump_abort <= 1'b0;
      end else begin
         trmt <= load;
         dump_done <= fin && last;
         dump_abort <= abort;
         if (start) begin
            og_chan <= dump_chan;
            rd_ptr <= trace_end + 1'b1;
            count <= '0;
         end
         if (og_hit) begin
            offset <= og_data[2*DW-1:DW];
            gain <= og_data[DW-1:0];
         end
         if (load) tx_data <= corr;
         if (fin && !last) begin
            rd_ptr <= rd_ptr + 1'b1;
            count <= count + 1'b1;
         end
      end
endmodule

// File: tb/tb_trace_dump_engine.sv
// tb_trace_dump_engine: scoreboarded dumps on the default engine plus a wide-sample small-depth instance
module tb_trace_dump_engine;
   logic clk = 1'b0;
   logic rst_n;
   logic we = 1'b0, cap_en = 1'b0, dump_req = 1'b0;
   logic [8:0] cap_addr = '0, trace_end = '0;
   logic [1:0] dump_chan = '0;
   logic [23:0] ch_rdata = '0;
   logic og_valid;
   logic [15:0] og_data;
   logic tx_resp, tx_spur = 1'b0;
   logic ram_en, og_req, trmt, busy, dump_done, dump_abort;
   logic [8:0] ram_addr;
   logic [1:0] og_chan;
   logic [7:0] tx_data;
   logic b_dump_req = 1'b0, b_og_valid = 1'b0, b_tx_done = 1'b0;
   logic [1:0] b_dump_chan = '0;
   logic [3:0] b_trace_end = '0;
   logic [47:0] b_ch_rdata = '0;
   logic [23:0] b_og_data = '0;
   logic b_ram_en, b_og_req, b_trmt, b_busy, b_dump_done, b_dump_abort;
   logic [3:0] b_ram_addr;
   logic [1:0] b_og_chan;
   logic [11:0] b_tx_data;
   int errors = 0, checks = 0;
   int n_trmt = 0, n_done = 0, n_abort = 0, n_tx = 0;
   int first_addr = -1, last_addr = -1;
   int exp_addr[$], exp_data[$];
   int got[512];
   logic og_auto = 1'b1;
   int cur_off = 0, cur_gain = 0;

   trace_dump_engine dut (
      .clk(clk), .rst_n(rst_n), .we(we), .cap_en(cap_en), .cap_addr(cap_addr),
      .dump_req(dump_req), .dump_chan(dump_chan), .trace_end(trace_end), .ch_rdata(ch_rdata),
      .og_valid(og_valid), .og_data(og_data), .tx_done(tx_resp | tx_spur),
      .ram_en(ram_en), .ram_addr(ram_addr), .og_req(og_req), .og_chan(og_chan),
      .tx_data(tx_data), .trmt(trmt), .busy(busy), .dump_done(dump_done), .dump_abort(dump_abort)
   );

   trace_dump_engine #(.NUM_CH(4), .DW(12), .AW(4)) dut_b (
      .clk(clk), .rst_n(rst_n), .we(1'b0), .cap_en(1'b0), .cap_addr(4'h0),
      .dump_req(b_dump_req), .dump_chan(b_dump_chan), .trace_end(b_trace_end), .ch_rdata(b_ch_rdata),
      .og_valid(b_og_valid), .og_data(b_og_data), .tx_done(b_tx_done),
      .ram_en(b_ram_en), .ram_addr(b_ram_addr), .og_req(b_og_req), .og_chan(b_og_chan),
      .tx_data(b_tx_data), .trmt(b_trmt), .busy(b_busy), .dump_done(b_dump_done), .dump_abort(b_dump_abort)
   );

   always #5 clk = ~clk;

   function automatic int ram1(input int ch, input int a);
      return ch == 0 ? (~a) & 255 : ch == 1 ? a & 255 : (a & 255) ^ 'h5A;
   endfunction

   function automatic int ram2(input int ch, input int a);
      return ch * 256 + a * 17;
   endfunction

   function automatic int corr(input int raw, input int off_u, input int g, input int dw);
      int mx, off, s, p;
      mx = (1 << dw) - 1;
      off = (off_u >= (1 << (dw - 1))) ? off_u - (1 << dw) : off_u;
      s = raw + off;
      s = (s < 0) ? 0 : (s > mx) ? mx : s;
      p = (s * g) / (1 << (dw - 1));
      return (p > mx) ? mx : p;
   endfunction

   task automatic check(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h, want %0h", nm, act, exp);
      end
   endtask

   // Synchronous RAMs with one cycle read latency
   always @(posedge clk) begin
      if (ram_en) ch_rdata <= {8'(ram1(2, int'(ram_addr))), 8'(ram1(1, int'(ram_addr))), 8'(ram1(0, int'(ram_addr)))};
      if (b_ram_en) b_ch_rdata <= {12'(ram2(3, int'(b_ram_addr))), 12'(ram2(2, int'(b_ram_addr))),
                                   12'(ram2(1, int'(b_ram_addr))), 12'(ram2(0, int'(b_ram_addr)))};
   end

   // Calibration source answers og_req in the same cycle unless held off
   initial begin
      og_valid = 1'b0;
      og_data = '0;
      forever begin
         @(posedge clk); #1;
         og_valid = og_req && og_auto;
         og_data = {8'(cur_off), 8'(cur_gain)};
      end
   end

   // Transmitter: completes 0, 1 or 2 cycles after each strobe in rotation
   initial begin
      tx_resp = 1'b0;
      forever begin
         @(posedge clk); #1;
         tx_resp = 1'b0;
         if (trmt) begin
            repeat (n_tx % 3) begin @(posedge clk); #1; end
            n_tx++;
            tx_resp = 1'b1;
         end
      end
   end

   // Scoreboard on the default engine
   always @(negedge clk) begin
      if (rst_n) begin
         if (ram_en && !we) begin
            check("rd-pending", exp_addr.size() > 0, 1);
            if (exp_addr.size() > 0) begin
               if (exp_addr.size() == 512) first_addr = int'(ram_addr);
               last_addr = int'(ram_addr);
               check("ram_addr", ram_addr, exp_addr.pop_front());
            end
         end
         if (trmt) begin
            n_trmt++;
            check("trmt-pending", exp_data.size() > 0, 1);
            if (exp_data.size() > 0) begin
               got[512 - exp_data.size()] = int'(tx_data);
               check("tx_data", tx_data, exp_data.pop_front());
            end
         end
         if (dump_done) begin
            n_done++;
            check("done-with-samples-left", exp_data.size(), 0);
         end
         if (dump_abort) n_abort++;
      end
   end

   task automatic flush();
      exp_addr.delete();
      exp_data.delete();
   endtask

   task automatic start_dump(input int ch, input int te, input int off, input int g);
      int a;
      flush();
      for (int k = 0; k < 512; k++) begin
         a = (te + 1 + k) % 512;
         exp_addr.push_back(a);
         exp_data.push_back(corr(ram1(ch, a), off, g, 8));
      end
      cur_off = off;
      cur_gain = g;
      @(posedge clk); #1;
      dump_chan = 2'(ch);
      trace_end = 9'(te);
      dump_req = 1'b1;
      @(posedge clk); #1;
      dump_req = 1'b0;
   endtask

   task automatic wait_done(input int d0, input string nm);
      int t = 0;
      while (n_done == d0 && t < 4000) begin @(negedge clk); t++; end
      check(nm, n_done, d0 + 1);
   endtask

   task automatic wait_trmt(input int n, input string nm);
      int t = 0;
      while (n_trmt < n && t < 1000) begin @(negedge clk); t++; end
      check(nm, n_trmt >= n, 1);
   endtask

   task automatic full_dump(input int ch, input int te, input int off, input int g, input string nm);
      int d0, t0;
      d0 = n_done;
      t0 = n_trmt;
      start_dump(ch, te, off, g);
      wait_done(d0, {nm, "-done"});
      check({nm, "-strobes"}, n_trmt - t0, 512);
      check({nm, "-idle"}, busy, 0);
   endtask

   task automatic run_b(input int off, input int g);
      int bq[$];
      int nb = 0;
      logic fin = 1'b0;
      for (int k = 0; k < 16; k++) bq.push_back(corr(ram2(3, (11 + k) % 16), off, g, 12));
      @(posedge clk); #1;
      b_dump_chan = 2'd3;
      b_trace_end = 4'hA;
      b_og_data = {12'(off), 12'(g)};
      b_dump_req = 1'b1;
      for (int t = 0; t < 300 && !fin; t++) begin
         @(posedge clk); #1;
         b_dump_req = 1'b0;
         b_og_valid = b_og_req;
         b_tx_done = b_trmt;
         if (b_trmt) begin
            nb++;
            check("b-pending", bq.size() > 0, 1);
            if (bq.size() > 0) check("b-tx_data", b_tx_data, bq.pop_front());
         end
         if (b_dump_done) fin = 1'b1;
      end
      b_og_valid = 1'b0;
      b_tx_done = 1'b0;
      check("b-strobes", nb, 16);
      check("b-done", fin, 1);
      check("b-abort", b_dump_abort, 0);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0, d0, a0;
      rst_n = 1'b1;
      #3 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst-busy", busy, 0);
      check("rst-trmt", trmt, 0);
      check("rst-og_req", og_req, 0);
      check("rst-done", dump_done, 0);
      check("rst-abort", dump_abort, 0);
      check("rst-tx_data", tx_data, 0);
      check("rst-ram_en", ram_en, 0);
      check("rst-b-busy", b_busy, 0);
      rst_n = 1'b1;
      run_b(0, 'h800);
      run_b('hCF0, 'hC00);
      full_dump(1, 'h1FF, 0, 'h80, "unity");
      check("unity-first", got[0], 'h00);
      check("unity-ff", got['hFF], 'hFF);
      check("unity-wrap", got['h100], 'h00);
      check("unity-last", got[511], 'hFF);
      full_dump(1, 'h1FF, 'h20, 'h80, "clamp-hi");
      check("clamp-hi-F0", got['hF0], 'hFF);
      full_dump(1, 'h1FF, 'hE0, 'h80, "clamp-lo");
      check("clamp-lo-10", got['h10], 'h00);
      full_dump(1, 'h1FF, 0, 'hFF, "gain-ff");
      check("gain-ff-40", got['h40], 'h7F);
      d0 = n_done;
      t0 = n_trmt;
      start_dump(0, 5, 'h05, 'h90);
      wait_trmt(t0 + 50, "wrap-progress");
      @(posedge clk); #1;
      dump_chan = 2'd2;
      trace_end = 9'h077;
      dump_req = 1'b1;
      @(posedge clk); #1;
      dump_req = 1'b0;
      wait_done(d0, "wrap-done");
      check("wrap-strobes", n_trmt - t0, 512);
      check("wrap-first-addr", first_addr, 'h006);
      check("wrap-last-addr", last_addr, 'h005);
      @(posedge clk); #1;
      we = 1'b1;
      dump_req = 1'b1;
      @(posedge clk); #1;
      dump_req = 1'b0;
      we = 1'b0;
      @(negedge clk);
      check("we-req-busy", busy, 0);
      check("we-req-og_req", og_req, 0);
      d0 = n_done;
      a0 = n_abort;
      t0 = n_trmt;
      og_auto = 1'b0;
      start_dump(2, 'h100, 0, 'h80);
      repeat (20) @(negedge clk);
      check("hold-og_req", og_req, 1);
      check("hold-busy", busy, 1);
      check("hold-og_chan", og_chan, 2);
      @(posedge clk); #1;
      tx_spur = 1'b1;
      @(posedge clk); #1;
      tx_spur = 1'b0;
      @(negedge clk);
      check("spur-og_req", og_req, 1);
      check("spur-strobes", n_trmt - t0, 0);
      @(posedge clk); #1;
      we = 1'b1;
      cap_en = 1'b0;
      cap_addr = 9'h0AA;
      @(negedge clk);
      check("cap-addr-hold", ram_addr, 'h0AA);
      check("cap-en-hold", ram_en, 0);
      @(negedge clk);
      check("hold-abort", dump_abort, 1);
      check("hold-abort-busy", busy, 0);
      check("hold-abort-og_req", og_req, 0);
      @(posedge clk); #1;
      we = 1'b0;
      og_auto = 1'b1;
      flush();
      check("hold-abort-count", n_abort - a0, 1);
      a0 = n_abort;
      t0 = n_trmt;
      start_dump(1, 'h1FF, 'h10, 'hA0);
      wait_trmt(t0 + 10, "abort-progress");
      @(posedge clk); #1;
      we = 1'b1;
      cap_en = 1'b1;
      cap_addr = 9'h123;
      @(negedge clk);
      check("cap-addr", ram_addr, 'h123);
      check("cap-en", ram_en, 1);
      @(negedge clk);
      check("abort-pulse", dump_abort, 1);
      check("abort-busy", busy, 0);
      repeat (20) @(negedge clk);
      check("abort-strobes", n_trmt - t0, 10);
      check("abort-count", n_abort - a0, 1);
      check("abort-no-done", n_done, d0);
      @(posedge clk); #1;
      we = 1'b0;
      cap_en = 1'b0;
      flush();
      a0 = n_abort;
      t0 = n_trmt;
      start_dump(2, 'h0FF, 'h7F, 'h40);
      wait_trmt(t0 + 5, "reset-progress");
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(negedge clk);
      check("mid-rst-busy", busy, 0);
      check("mid-rst-trmt", trmt, 0);
      check("mid-rst-tx_data", tx_data, 0);
      check("mid-rst-og_req", og_req, 0);
      check("mid-rst-ram_en", ram_en, 0);
      repeat (2) @(posedge clk);
      #1;
      flush();
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      check("post-rst-no-done", n_done, d0);
      check("post-rst-no-abort", n_abort, a0);
      full_dump(2, 'h0FF, 'h7F, 'h40, "fresh");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
